// File: rtl/saradc_11b_dig_seq.sv
// saradc_11b_dig_seq: priority plus round-robin channel scheduler for the 11-bit SAR ADC conversion FSM
module saradc_11b_dig_seq #(
    parameter int N_CHANNELS  = 16,
    parameter int N_CONV_BITS = 11,
    parameter int CH_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   nres,
    input  logic                   enable_i,
    input  logic [N_CHANNELS-1:0]  req_i,
    input  logic                   prio_en_i,
    input  logic [CH_W-1:0]        prio_ch_i,
    output logic                   conv_start_o,
    output logic [CH_W-1:0]        conv_ch_o,
    input  logic                   conv_done_i,
    input  logic [N_CONV_BITS-1:0] conv_data_i,
    output logic                   res_valid_o,
    output logic [CH_W-1:0]        res_ch_o,
    output logic [N_CONV_BITS-1:0] res_data_o,
    input  logic                   res_ready_i,
    output logic [N_CHANNELS-1:0]  overrun_o,
    input  logic                   ovr_clr_i,
    output logic                   timeout_o,
    output logic                   idle_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
    state_t                  state, state_nx;
    logic [N_CHANNELS-1:0]   pending, pending_nx, grant_clr, ovr_set;
    logic [CH_W-1:0]         last_grant, rr_ch, grant_ch, idx;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    prio_hit, grant, timeout_hit;
    always_comb begin
        rr_ch = '0;
        idx = '0;
        for (int i = N_CHANNELS; i >= 1; i--) begin
            idx = CH_W'((int'(last_grant) + i) % N_CHANNELS);
            rr_ch = pending[idx] ? idx : rr_ch;
        end
    end
    assign prio_hit    = prio_en_i && |(pending & (N_CHANNELS'(1) << prio_ch_i));
    assign grant       = state == IDLE && enable_i && |pending;
    assign grant_ch    = prio_hit ? prio_ch_i : rr_ch;
    assign grant_clr   = grant ? N_CHANNELS'(1) << grant_ch : '0;
    assign pending_nx  = (pending & ~grant_clr) | req_i;
    assign ovr_set     = req_i & pending & ~grant_clr;
    assign timeout_hit = state == WAIT && !conv_done_i && wait_cnt == CNT_W'(TIMEOUT_CYC - 2);
    assign state_nx    = (state == IDLE)  ? (grant ? START : IDLE) :
                         (state == START) ? WAIT :
                         (state == WAIT)  ? (conv_done_i ? OUT : timeout_hit ? IDLE : WAIT) :
                         (res_ready_i ? IDLE : OUT);
    always_ff @(posedge clk) begin
        if (!nres) begin
            state        <= IDLE;
            pending      <= '0;
            overrun_o    <= '0;
            last_grant   <= CH_W'(N_CHANNELS - 1);
            conv_start_o <= 1'b0;
            conv_ch_o    <= '0;
            res_valid_o  <= 1'b0;
            res_ch_o     <= '0;
            res_data_o   <= '0;
            timeout_o    <= 1'b0;
            wait_cnt     <= '0;
            idle_o       <= 1'b1;
        end else begin
            state        <= state_nx;
            pending      <= pending_nx;
            overrun_o    <= (ovr_clr_i ? '0 : overrun_o) | ovr_set;
            conv_start_o <= grant;
            timeout_o    <= timeout_hit;
            wait_cnt     <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            idle_o       <= state_nx == IDLE && pending_nx == '0;
            if (grant) begin
                conv_ch_o  <= grant_ch;
                last_grant <= grant_ch;
            end
            if (state == WAIT && conv_done_i) begin
                res_valid_o <= 1'b1;
                res_ch_o    <= conv_ch_o;
                res_data_o  <= conv_data_i;
            end else if (state == OUT && res_ready_i) begin
                res_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_saradc_11b_dig_seq.sv
// tb_saradc_11b_dig_seq: directed self-checking bench for the conversion scheduler
module tb_saradc_11b_dig_seq;
    localparam int N = 16, B = 11, CW = 4, T = 64;
    logic          clk = 1'b0, nres = 1'b0, enable_i = 1'b0, prio_en_i = 1'b0;
    logic          conv_done_i = 1'b0, res_ready_i = 1'b0, ovr_clr_i = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic [CW-1:0] prio_ch_i = '0;
    logic [B-1:0]  conv_data_i = '0;
    logic          conv_start_o, res_valid_o, timeout_o, idle_o;
    logic [CW-1:0] conv_ch_o, res_ch_o;
    logic [B-1:0]  res_data_o;
    logic [N-1:0]  overrun_o;
    int  cyc = 0, n_chk = 0, n_fail = 0, n_start = 0, resp_cnt = 0, resp_ch = 0;
    bit  no_done = 1'b0, auto_ready = 1'b1;
    int  grant_q[$], start_q[$], res_q[$];

    saradc_11b_dig_seq dut (
        .clk(clk), .nres(nres), .enable_i(enable_i), .req_i(req_i),
        .prio_en_i(prio_en_i), .prio_ch_i(prio_ch_i),
        .conv_start_o(conv_start_o), .conv_ch_o(conv_ch_o),
        .conv_done_i(conv_done_i), .conv_data_i(conv_data_i),
        .res_valid_o(res_valid_o), .res_ch_o(res_ch_o), .res_data_o(res_data_o),
        .res_ready_i(res_ready_i), .overrun_o(overrun_o), .ovr_clr_i(ovr_clr_i),
        .timeout_o(timeout_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_res(input string tag, input int n);
        int k = 0;
        while (res_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, res_q.size() >= n, 1);
    endtask

    task automatic wait_starts(input string tag, input int n);
        int k = 0;
        while (n_start < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_start >= n, 1);
    endtask

    // conversion FSM model: done 12 cycles after each start with data = ch*100, plus result sink
    initial forever begin
        @(negedge clk);
        conv_done_i = 1'b0;
        res_ready_i = auto_ready;
        if (conv_start_o) begin
            n_start++;
            grant_q.push_back(int'(conv_ch_o));
            start_q.push_back(cyc);
            resp_ch  = int'(conv_ch_o);
            resp_cnt = 12;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && !no_done) begin
                conv_done_i = 1'b1;
                conv_data_i = B'(resp_ch * 100);
            end
        end
        if (res_valid_o && res_ready_i) res_q.push_back(int'(res_ch_o) * 10000 + int'(res_data_o));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, s, e, ns, bad, k, tc;
        logic [CW-1:0] ch;
        logic [B-1:0]  data;
        bit vseen;
        req_i = '1;
        repeat (2) @(negedge clk);
        chk("rst_start", conv_start_o, 0);
        chk("rst_ch", conv_ch_o, 0);
        chk("rst_valid", res_valid_o, 0);
        chk("rst_res_ch", res_ch_o, 0);
        chk("rst_res_data", res_data_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_idle", idle_o, 1);
        nres  = 1'b1;
        req_i = '0;
        @(negedge clk);
        chk("idle_after_rst", idle_o, 1);
        enable_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_pending", n_start, 0);

        t = cyc;
        req_i = 16'h0013;
        @(negedge clk);
        req_i = '0;
        wait_res("rr_wait", 3);
        repeat (5) @(negedge clk);
        chk("rr_starts", n_start, 3);
        chk("rr_g0", grant_q[0], 0);
        chk("rr_g1", grant_q[1], 1);
        chk("rr_g2", grant_q[2], 4);
        chk("rr_r0", res_q[0], 0);
        chk("rr_r1", res_q[1], 10100);
        chk("rr_r2", res_q[2], 40400);
        chk("rr_latency", start_q[0], t + 2);
        chk("rr_gap", start_q[1] - start_q[0], 15);

        grant_q.delete();
        res_q.delete();
        req_i = 16'h4000;
        @(negedge clk);
        req_i = '0;
        wait_res("pr_ch14", 1);
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        req_i = 16'h8204;
        @(negedge clk);
        req_i     = '0;
        prio_en_i = 1'b1;
        prio_ch_i = 4'd9;
        @(negedge clk);
        enable_i = 1'b1;
        wait_res("pr_wait", 4);
        chk("pr_g14", grant_q[0], 14);
        chk("pr_g9", grant_q[1], 9);
        chk("pr_g15", grant_q[2], 15);
        chk("pr_g2", grant_q[3], 2);
        prio_en_i = 1'b0;

        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        req_i = 16'h0008;
        @(negedge clk);
        req_i = '0;
        @(negedge clk);
        chk("ovr_none", overrun_o, 0);
        req_i = 16'h0008;
        @(negedge clk);
        req_i = '0;
        chk("ovr_set", overrun_o, 16'h0008);
        ovr_clr_i = 1'b1;
        @(negedge clk);
        ovr_clr_i = 1'b0;
        chk("ovr_clr", overrun_o, 0);
        req_i = 16'h0020;
        @(negedge clk);
        req_i     = 16'h0020;
        ovr_clr_i = 1'b1;
        @(negedge clk);
        req_i     = '0;
        ovr_clr_i = 1'b0;
        chk("ovr_clr_race", overrun_o, 16'h0020);

        grant_q.delete();
        res_q.delete();
        auto_ready = 1'b0;
        enable_i   = 1'b1;
        k = 0;
        while (!res_valid_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("bp_valid", res_valid_o, 1);
        ch   = res_ch_o;
        data = res_data_o;
        ns   = n_start;
        bad  = 0;
        repeat (20) begin
            @(negedge clk);
            if (!res_valid_o || res_ch_o !== ch || res_data_o !== data) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_ch", ch, 3);
        chk("bp_data", data, 300);
        chk("bp_no_start", n_start, ns);

        no_done    = 1'b1;
        auto_ready = 1'b1;
        wait_starts("tmo_start", ns + 1);
        s = start_q[$];
        req_i = 16'h0080;
        @(negedge clk);
        req_i = '0;
        vseen = 1'b0;
        k = 0;
        while (!timeout_o && k < 200) begin
            @(negedge clk);
            if (res_valid_o) vseen = 1'b1;
            k++;
        end
        tc = cyc;
        chk("tmo_seen", timeout_o, 1);
        chk("tmo_ch5", grant_q[1], 5);
        chk("tmo_cycle", tc - s, T);
        chk("tmo_no_valid", vseen, 0);
        @(negedge clk);
        chk("tmo_pulse", timeout_o, 0);
        no_done = 1'b0;
        wait_starts("tmo_next", ns + 2);
        chk("tmo_next_ch", grant_q[$], 7);
        chk("tmo_next_cycle", start_q[$], s + T + 1);
        wait_res("tmo_res", 2);
        chk("tmo_res7", res_q[1], 70700);

        req_i = 16'h0400;
        @(negedge clk);
        req_i = '0;
        wait_starts("en_start", n_start + 1);
        repeat (3) @(negedge clk);
        enable_i = 1'b0;
        req_i    = 16'h0100;
        @(negedge clk);
        req_i = '0;
        wait_res("en_res_wait", 3);
        chk("en_res10", res_q[2], 101000);
        ns = n_start;
        repeat (10) @(negedge clk);
        chk("en_no_grant", n_start, ns);
        chk("en_not_idle", idle_o, 0);
        e = cyc;
        enable_i = 1'b1;
        wait_starts("en_restart", ns + 1);
        chk("en_restart_ch", grant_q[$], 8);
        chk("en_restart_cycle", start_q[$], e + 1);

        repeat (4) @(negedge clk);
        nres = 1'b0;
        @(negedge clk);
        nres = 1'b1;
        chk("mid_rst_valid", res_valid_o, 0);
        chk("mid_rst_idle", idle_o, 1);
        chk("mid_rst_ch", conv_ch_o, 0);
        repeat (15) @(negedge clk);
        chk("mid_rst_done_ignored", res_valid_o, 0);
        chk("mid_rst_no_result", res_q.size(), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/saradc_11b_dig_seq.md
# saradc_11b_dig_seq

Channel conversion scheduler for the 11-bit SAR ADC digital core. It collects per-channel conversion requests and arbitrates them with one programmable priority channel plus round-robin. It issues one conversion at a time to the conversion FSM through a start/done handshake and delivers each result with its channel tag over a valid/ready output. It sits between the request sources (register block and trigger logic) and the conversion FSM, and is gated by the startup sequencer's conversion enable.

## Interface
- N_CHANNELS, 16, number of analog input channels (2..16)
- N_CONV_BITS, 11, conversion result width
- CH_W, 4, channel index width; $clog2(N_CHANNELS), minimum 1
- TIMEOUT_CYC, 64, maximum cycles spent in WAIT before abort (≥4)

Ports:
- clk  in  1  core clock
- nres  in  1  reset, synchronous and active-low; all state updates on rising clk
- enable_i  in  1  conversion enable from startup sequencer
- req_i  in  N_CHANNELS  per-channel request; each cycle high sets that channel's pending bit
- prio_en_i  in  1  priority channel enable
- prio_ch_i  in  CH_W  priority channel index; values ≥N_CHANNELS are ignored
- conv_start_o  out  1  one-cycle start pulse to the conversion FSM
- conv_ch_o  out  CH_W  granted channel; stable from START through end of WAIT
- conv_done_i  in  1  conversion complete; sampled only in WAIT
- conv_data_i  in  N_CONV_BITS  result; valid with conv_done_i
- res_valid_o  out  1  result available
- res_ch_o  out  CH_W  channel tag of the result
- res_data_o  out  N_CONV_BITS  result data
- res_ready_i  in  1  consumer accepts the result
- overrun_o  out  N_CHANNELS  sticky: request arrived while already pending
- ovr_clr_i  in  1  clears overrun_o
- timeout_o  out  1  one-cycle pulse on a WAIT abort
- idle_o  out  1  high in IDLE with no pending request

## Operation
- Reset (nres=0 at a clock edge): state IDLE; pending=0; overrun_o=0; last_grant=N_CHANNELS-1; conv_start_o=0; conv_ch_o=0; res_valid_o=0; res_ch_o=0; res_data_o=0; timeout_o=0; wait counter=0. idle_o=1 after reset. Reset mid-conversion drops the conversion and any held result.
- Pending: pending[k] <= (pending[k] & ~grant_clr[k]) | req_i[k].
  - A request wins over a same-cycle grant clear; the bit stays 1 and no overrun is flagged.
  - overrun_o[k] sets when req_i[k]=1 and pending[k]=1 and not cleared by a grant that cycle.
  - ovr_clr_i clears all overrun bits. A same-cycle new overrun wins (the bit stays set).
  - Pending bits accumulate in every state, including while enable_i=0.
- Arbitration happens in IDLE when enable_i=1 and any pending bit is set:
  - If prio_en_i=1 and pending[prio_ch_i]=1, grant prio_ch_i.
  - Otherwise grant the first pending channel scanning upward from last_grant+1, wrapping at N_CHANNELS-1 to 0.
  - On grant: clear that pending bit, load conv_ch_o, update last_grant (priority grants also update it), go to START.
- FSM states:
  - IDLE: arbitrate as above.
  - START: conv_start_o=1 for exactly one cycle; go to WAIT; clear the wait counter.
  - WAIT: on conv_done_i=1, capture res_data_o<=conv_data_i and res_ch_o<=conv_ch_o, set res_valid_o, go to OUT. Otherwise increment the counter; when it reaches TIMEOUT_CYC-1 without done, pulse timeout_o, go to IDLE, produce no result (the pending bit stays cleared).
  - OUT: hold res_valid_o, res_ch_o and res_data_o stable until res_ready_i=1, then clear res_valid_o and go to IDLE.
- enable_i falling in START/WAIT/OUT: the current transaction completes normally. No new grant is made until enable_i=1.
- conv_done_i outside WAIT is ignored.

## Timing
- req_i[k] high at cycle t sets pending at t+1. From IDLE with enable_i=1, the grant is made at t+1 and conv_start_o is high at t+2.
- conv_done_i at cycle d sets res_valid_o high from d+1.
- res_ready_i high at cycle r while res_valid_o=1 makes res_valid_o low at r+1 and returns to IDLE at r+1. The next conv_start_o is at r+2 at the earliest.
- Result channel throughput: one result per (conversion time + 4) cycles minimum.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold nres=0 for 2 clk with req_i=16'hFFFF. All outputs follow the reset values; pending is empty; idle_o=1 one cycle after nres rises with req_i=0.
- Round-robin: req_i=16'h0013 for one cycle; the FSM model returns done after 12 cycles with data=ch*100. Grants in order 0,1,4. Results (0,0),(1,100),(4,400). Exactly 3 conv_start_o pulses.
- Priority plus wrap: last_grant=14, pending={2,9,15}, prio_en_i=1, prio_ch_i=9. Grant order 9,15,2.
- Overrun and clear: req_i[3] pulsed twice while channel 3 is pending → overrun_o=16'h0008. Pulse ovr_clr_i → 0. A simultaneous new overrun on channel 5 together with ovr_clr_i leaves 16'h0020.
- Backpressure and timeout: hold res_ready_i=0 for 20 cycles → res_data_o/res_ch_o stable, no new conv_start_o. Then with the FSM model never asserting done: timeout_o pulses exactly TIMEOUT_CYC cycles after START, no res_valid_o, next pending channel granted.
- Enable and reset mid-operation: drop enable_i in WAIT → the result is still delivered and no further grant occurs while pending=16'h0100. Raise enable_i → channel 8 starts 1 cycle later. Assert nres=0 during WAIT → IDLE and res_valid_o=0 the next cycle.
